// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// Optional software restart is enabled by defining RESET_SEQ_SWRST_EN.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      DELAY    = 2'd0,
      ACK_WAIT = 2'd1,
      DONE     = 2'd2,
      FAULT    = 2'd3
   } seq_state_e;

   localparam int DEF_NUM_STAGES  = 4;
   localparam int DEF_STAGE_DELAY = 16;
   localparam int DEF_ACK_TIMEOUT = 1024;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // Stage index width; never zero even for a single stage.
   function automatic int idx_width(input int n);
      return (clog2(n) > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Per-domain reset / acknowledge bundle between the sequencer and its domains.
interface reset_sequencer_if
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int IDX_W      = idx_width(NUM_STAGES)
);
   logic [NUM_STAGES-1:0] STAGE_ACK;
   logic [NUM_STAGES-1:0] STAGE_RST_N;
   logic                  SEQ_DONE;
   logic                  SEQ_FAULT;
   logic [IDX_W-1:0]      FAULT_STAGE;

   modport master (
      input  STAGE_ACK,
      output STAGE_RST_N, SEQ_DONE, SEQ_FAULT, FAULT_STAGE
   );

   modport slave (
      output STAGE_ACK,
      input  STAGE_RST_N, SEQ_DONE, SEQ_FAULT, FAULT_STAGE
   );
endinterface

// File: rtl/reset_seq_timer.sv
// Shared up-counter: synchronous clear, count enable and terminal-count compare.
module reset_seq_timer
   import reset_seq_pkg::*;
#(
   parameter int CNT_W = 11
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] tc_val,
   output logic             tc
);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLK) begin
      if (!rst_n || clr) cnt_q <= '0;
      else if (en)       cnt_q <= cnt_q + 1'b1;
   end

   assign tc = (cnt_q == tc_val);
endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in order, each after a settling delay and an ack.
// Define RESET_SEQ_SWRST_EN to add SW_RST_REQ, restarting the sequence from DONE/FAULT.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES  = DEF_NUM_STAGES,
   parameter int STAGE_DELAY = DEF_STAGE_DELAY,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic               CLK,
   input  logic               FABRIC_RESET_N,
`ifdef RESET_SEQ_SWRST_EN
   input  logic               SW_RST_REQ,
`endif
   reset_sequencer_if.master  seq
);
   localparam int IDX_W = idx_width(NUM_STAGES);
   localparam int CNT_W = clog2(((STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT) + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   seq_state_e            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      fstage_q, fstage_d;
   logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
   logic                  tmr_clr, tmr_en, tmr_tc;
   logic [CNT_W-1:0]      tmr_tc_val;
   logic                  ack_cur;
   logic                  sw_rst;

`ifdef RESET_SEQ_SWRST_EN
   assign sw_rst = SW_RST_REQ;
`else
   assign sw_rst = 1'b0;
`endif

   assign ack_cur = seq.STAGE_ACK[idx_q];

   reset_seq_timer #(.CNT_W(CNT_W)) u_timer (
      .CLK    (CLK),
      .rst_n  (FABRIC_RESET_N),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .tc_val (tmr_tc_val),
      .tc     (tmr_tc)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      fstage_d   = fstage_q;
      rst_n_d    = rst_n_q;
      tmr_clr    = 1'b0;
      tmr_en     = 1'b0;
      tmr_tc_val = CNT_W'(STAGE_DELAY - 1);
      case (state_q)
         DELAY: begin
            if (tmr_tc) begin
               rst_n_d[idx_q] = 1'b1;
               tmr_clr        = 1'b1;
               state_d        = ACK_WAIT;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ACK_WAIT: begin
            tmr_tc_val = CNT_W'(ACK_TIMEOUT - 1);
            // Ack is checked first so it wins over a coincident timeout.
            if (ack_cur) begin
               tmr_clr = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  rst_n_d = '1;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = DELAY;
               end
            end else if (tmr_tc) begin
               tmr_clr  = 1'b1;
               state_d  = FAULT;
               rst_n_d  = '0;
               fstage_d = idx_q;
            end else begin
               tmr_en = 1'b1;
            end
         end
         DONE, FAULT: begin
            if (sw_rst) begin
               state_d  = DELAY;
               idx_d    = '0;
               fstage_d = '0;
               rst_n_d  = '0;
               tmr_clr  = 1'b1;
            end
         end
         default: state_d = DELAY;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!FABRIC_RESET_N) begin
         state_q  <= DELAY;
         idx_q    <= '0;
         fstage_q <= '0;
         rst_n_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         fstage_q <= fstage_d;
         rst_n_q  <= rst_n_d;
      end
   end

   assign seq.STAGE_RST_N = rst_n_q;
   assign seq.SEQ_DONE    = (state_q == DONE);
   assign seq.SEQ_FAULT   = (state_q == FAULT);
   assign seq.FAULT_STAGE = fstage_q;
endmodule
